// File: rtl/lsu_pkg.sv
// Shared LSU definitions: scheduler FSM states and the wrapping tag-age test
// used by the load scheduler, load queue and store-queue searcher.
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_e;

  // True when tag a is the same age as or younger than tag b in a w-bit
  // wrapping tag space: the w-bit difference a-b, read as signed, is >= 0.
  // Operands are zero-extended to 32 bits; the difference is shifted so its
  // w-bit sign lands in bit 31.
  function automatic logic tag_younger_eq(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return ~d[31];
  endfunction

endpackage

// File: rtl/ldq_load_scheduler_oldest_ready_picker.sv
// Priority encoder over the head-relative eligibility vector: bit 0 is the
// oldest entry, so the lowest set bit wins.
module oldest_ready_picker #(
  parameter int N  = 8,
  parameter int KW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  output logic          found,
  output logic [KW-1:0] offset
);

  // Scan from youngest to oldest so the oldest eligible offset is written last
  always_comb begin
    found  = |elig;
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[k]) offset = KW'(k);
    end
  end

endmodule

// File: rtl/ldq_load_scheduler.sv
// Load scheduler: issues the oldest ready load-queue entry to data memory
// over a valid/ready handshake, reports each issue back to the LDQ, masks
// re-issue of an entry until its executed bit lands, and cancels requests
// killed by a ROB flush.
// Optional: define LDQ_SCHED_PERF_CNT_EN to add saturating issue/stall counters.
module ldq_load_scheduler
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int LDQ_SIZE      = 8,
  parameter int LDQ_TAG_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_valid,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_address_valid,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_sleeping,
  input  logic [LDQ_SIZE-1:0]               ldq_rotated_executed,
  input  logic [LDQ_SIZE*XLEN-1:0]          ldq_address,
  input  logic [LDQ_SIZE*ROB_TAG_WIDTH-1:0] ldq_rob_tag,
  input  logic [LDQ_TAG_WIDTH-1:0]          head,
  input  logic                              flush,
  input  logic [ROB_TAG_WIDTH-1:0]          flush_rob_tag,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [XLEN-1:0]                   mem_req_address,
  output logic [ROB_TAG_WIDTH-1:0]          mem_req_rob_tag,
  output logic                              load_fired,
  output logic [LDQ_TAG_WIDTH-1:0]          load_fired_tag
`ifdef LDQ_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_issued,
  output logic [31:0]                       perf_stall
`endif
);

  localparam int IDXW = $clog2(LDQ_SIZE);

  lsu_state_e                 state_q, state_d;
  logic [LDQ_SIZE-1:0]        block_q, block_rot, elig;
  logic                       found;
  logic [IDXW-1:0]            k;
  logic [LDQ_TAG_WIDTH-1:0]   pick_tag, tag_q, fired_tag_q;
  logic [IDXW-1:0]            pick_idx;
  logic [XLEN-1:0]            addr_q;
  logic [ROB_TAG_WIDTH-1:0]   rob_q;
  logic                       fired_q, kill, fire, latch;

  // Block mask is kept by physical index; rotate it into head-relative order
  always_comb begin
    block_rot = '0;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      block_rot[i] = block_q[IDXW'(head[IDXW-1:0] + IDXW'(i))];
    end
  end

  assign elig = ldq_rotated_valid & ldq_rotated_address_valid &
                ~ldq_rotated_sleeping & ~ldq_rotated_executed & ~block_rot;

  oldest_ready_picker #(.N(LDQ_SIZE), .KW(IDXW)) u_picker (
    .elig   (elig),
    .found  (found),
    .offset (k)
  );

  // Tag arithmetic wraps in LDQ_TAG_WIDTH; low bits give the physical slot
  assign pick_tag = head + LDQ_TAG_WIDTH'(k);
  assign pick_idx = pick_tag[IDXW-1:0];

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: select in IDLE, hold REQ until handshake or flush kill
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found && !flush) state_d = REQ;
      REQ:     if (kill || mem_req_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request is live exactly while in REQ; payload reads 0 otherwise
  always_comb begin
    mem_req_valid   = (state_q == REQ);
    kill            = mem_req_valid && flush &&
                      tag_younger_eq(32'(rob_q), 32'(flush_rob_tag), ROB_TAG_WIDTH);
    fire            = mem_req_valid && mem_req_ready && !kill;
    latch           = (state_q == IDLE) && found && !flush;
    mem_req_address = mem_req_valid ? addr_q : '0;
    mem_req_rob_tag = mem_req_valid ? rob_q  : '0;
  end

  // Request payload latch, issue pulse and one-cycle block of the issued slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q       <= '0;
      addr_q      <= '0;
      rob_q       <= '0;
      fired_q     <= 1'b0;
      fired_tag_q <= '0;
      block_q     <= '0;
    end else begin
      if (latch) begin
        tag_q  <= pick_tag;
        addr_q <= ldq_address[pick_idx*XLEN +: XLEN];
        rob_q  <= ldq_rob_tag[pick_idx*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
      end
      fired_q     <= fire;
      fired_tag_q <= fire ? tag_q : '0;
      block_q     <= '0;
      if (fire) block_q[tag_q[IDXW-1:0]] <= 1'b1;
    end
  end

  assign load_fired     = fired_q;
  assign load_fired_tag = fired_tag_q;

`ifdef LDQ_SCHED_PERF_CNT_EN
  // Saturating counters of completed issues and back-pressured REQ cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire && !(&perf_issued)) perf_issued <= perf_issued + 32'd1;
      if (mem_req_valid && !mem_req_ready && !(&perf_stall))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ldq_load_scheduler.md
Name: ldq_load_scheduler

Overview:
- Picks the oldest load-queue entry that is ready to execute and issues it to the data-memory request port with a valid/ready handshake.
- Sits between the load queue and the memory interface.
- Drives load_fired/load_fired_tag back to the load queue and the store-queue searcher.
- Prevents double issue of an entry during the one-cycle window before that entry's executed bit updates, and cancels flushed requests.

Parameters:
- XLEN, 32, data/address width
- ROB_TAG_WIDTH, 5, ROB tag width (extended; wrap-compared with signed difference)
- LDQ_SIZE, 8, load queue entries (power of 2)
- LDQ_TAG_WIDTH, 4, load queue tag width (>= $clog2(LDQ_SIZE); extra bits wrap)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- ldq_rotated_valid  in  LDQ_SIZE  valid bits, head at bit 0
- ldq_rotated_address_valid  in  LDQ_SIZE  address-valid bits, head at bit 0
- ldq_rotated_sleeping  in  LDQ_SIZE  sleeping bits, head at bit 0
- ldq_rotated_executed  in  LDQ_SIZE  executed bits, head at bit 0
- ldq_address  in  LDQ_SIZE*XLEN  per-entry address, physical index order
- ldq_rob_tag  in  LDQ_SIZE*ROB_TAG_WIDTH  per-entry ROB tag, physical index order
- head  in  LDQ_TAG_WIDTH  load queue head pointer
- flush  in  1  ROB flush
- flush_rob_tag  in  ROB_TAG_WIDTH  flush this tag and everything younger
- mem_req_valid  out  1  request to data memory
- mem_req_ready  in  1  memory accepts request
- mem_req_address  out  XLEN  load address
- mem_req_rob_tag  out  ROB_TAG_WIDTH  tag returned later as load_succeeded_rob_tag
- load_fired  out  1  one-cycle pulse: entry issued this cycle
- load_fired_tag  out  LDQ_TAG_WIDTH  LDQ tag of the issued entry

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, mem_req_valid=0, mem_req_address=0, mem_req_rob_tag=0, load_fired=0, load_fired_tag=0, block mask=0.
- Eligibility, per rotated offset k: rotated_valid & rotated_address_valid & ~rotated_sleeping & ~rotated_executed & ~block[k].
- Selection: lowest eligible k wins (oldest first).
  - Chosen tag = head + k, computed in LDQ_TAG_WIDTH arithmetic (modular wrap).
  - Physical index = low $clog2(LDQ_SIZE) bits of the chosen tag.
- Block mask:
  - Register of physical indices issued last cycle.
  - Bit set on the cycle load_fired=1; cleared the following cycle.
  - Covers the window before the LDQ registers executed=1.
  - Rotated by head before use.
- FSM:
  - IDLE: if any entry is eligible and !flush, latch index, address and rob_tag; assert mem_req_valid next cycle; go to REQ.
  - REQ: hold mem_req_valid, address and rob_tag stable until mem_req_ready.
    - On the handshake cycle (valid&ready): load_fired=1 and load_fired_tag=latched tag, registered so they appear the cycle after the handshake; set the block bit; return to IDLE.
  - Throughput: at most one issue per 2 cycles. The next selection is evaluated in IDLE after the block bit is set.
- Flush:
  - While in REQ, if flush and $signed(mem_req_rob_tag - flush_rob_tag) >= 0: drop the request (mem_req_valid=0 next cycle), no load_fired, go to IDLE.
  - An older pending request survives the flush and is unaffected.
  - Flush in IDLE suppresses selection that cycle.
- Entry drops eligibility while in REQ (e.g. invalidated): the request is still held until the handshake. Flush is the only cancel path.
- Empty or no eligible entry: stay in IDLE, all outputs deasserted.
- Head wrap: correct ordering is required when head+k crosses LDQ_SIZE or the tag wraps.
- mem_req_ready while mem_req_valid=0: ignored.

Optional Feature:
- Macro: LDQ_SCHED_PERF_CNT_EN
- Defined: adds outputs perf_issued (32b, increments on each handshake) and perf_stall (32b, increments on each REQ cycle with mem_req_ready=0). Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package lsu_pkg: FSM state enum (IDLE, REQ) and the tag-age comparison function (signed-difference older/younger test), shared with the LDQ and STQ.
- One sub-module, oldest_ready_picker: combinational priority encoder over the rotated eligibility vector, producing found and offset k.

Test Plan:
- Head=0; entries 2 and 5 eligible; ready=1 -> request for entry 2 (address and rob_tag of entry 2); load_fired_tag=2 after the handshake; entry 5 issued on the next IDLE pass.
- Head=6, LDQ_SIZE=8; entries 7 and 1 eligible -> entry 7 issued first, then tag 9 (index 1); verify head+k wrap.
- mem_req_ready held low 4 cycles -> mem_req_valid/address/rob_tag stable for 4 cycles; single load_fired pulse after ready.
- Pending request with rob_tag=12; flush with flush_rob_tag=10 -> request dropped, no load_fired. Repeat with flush_rob_tag=13 -> request survives and completes.
- Executed bit still 0 for one cycle after issue -> block mask prevents re-issue of the same index.
- Assert reset mid-REQ -> all outputs 0 immediately, without waiting for clk; FSM in IDLE.
